instruction_fetch: RTL and testbench

Fetch front end for the RV core. Owns the PC and issues word addresses and enables to the synchronous instruction ROM, which has a 1-cycle read latency. It pairs each returned word with its PC, buffers it in a 2-entry queue, and hands it to decode over a valid/ready handshake. Redirects from execute (branches and jumps) flush all in-flight and buffered fetches.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV core definitions: address width, fetch constants and the fetch queue entry.
package riscv_pkg;

   localparam int ALEN          = 32;
   localparam int IF_FIFO_DEPTH = 2;
   localparam int IF_FIFO_CNT_W = $clog2(IF_FIFO_DEPTH + 1);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [ALEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

   function automatic logic [ALEN-1:0] word_align(input logic [ALEN-1:0] addr);
      return {addr[ALEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs between the ROM and decode, with a flush.
module fetch_fifo
   import riscv_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             wr_data,
   input  logic                     pop,
   output fetch_entry_t             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [IF_FIFO_CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(IF_FIFO_DEPTH);

   fetch_entry_t     mem [IF_FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == IF_FIFO_CNT_W'(IF_FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + IF_FIFO_CNT_W'(1);
            2'b01:   count <= count - IF_FIFO_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the PC, drives the 1-cycle-latency instruction ROM and
// queues returned words for decode; redirects from execute flush everything in flight.
module instruction_fetch
   import riscv_pkg::*;
#(
   parameter logic [ALEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [ALEN-1:0] redirect_pc,
   output logic            imem_en,
   output logic [ALEN-1:0] imem_addr,
   input  logic [31:0]     imem_instr,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [ALEN-1:0] if_pc,
   output logic [31:0]     if_instr
);

   logic [ALEN-1:0]          pc_q;
   logic                     pend_q;
   logic [ALEN-1:0]          pend_pc_q;

   logic [ALEN-1:0]          redirect_addr;
   logic                     pop;
   logic                     push;
   logic                     credit_ok;
   logic                     issue;
   fetch_entry_t             push_entry;
   fetch_entry_t             head;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [IF_FIFO_CNT_W-1:0] fifo_count;

   assign redirect_addr = word_align(redirect_pc);
   assign pop           = if_valid && if_ready;

   // A slot is free if the queue plus the in-flight response leaves room, counting this cycle's pop.
   assign credit_ok = (3'(fifo_count) + 3'(pend_q)) < (3'(IF_FIFO_DEPTH) + 3'(pop));
   assign issue     = rst_n && (redirect_valid || credit_ok);

   assign imem_en   = issue;
   assign imem_addr = redirect_valid ? redirect_addr : pc_q;

   // The response arriving during a redirect belongs to the abandoned stream.
   assign push       = pend_q && !redirect_valid;
   assign push_entry = '{pc: pend_pc_q, instr: imem_instr};

   fetch_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (redirect_valid),
      .push    (push),
      .wr_data (push_entry),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign if_valid = !fifo_empty;
   assign if_pc    = fifo_empty ? '0 : head.pc;
   assign if_instr = fifo_empty ? NOP_INSTR : head.instr;

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else if (redirect_valid) begin
         pc_q      <= redirect_addr + ALEN'(4);
         pend_q    <= 1'b1;
         pend_pc_q <= redirect_addr;
      end else if (issue) begin
         pc_q      <= pc_q + ALEN'(4);
         pend_q    <= 1'b1;
         pend_pc_q <= pc_q;
      end else begin
         pend_q    <= 1'b0;
      end
   end

   overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a modelled ROM, a stream-level reference
// model of expected PCs and a monitor that scores every instruction decode accepts.
module tb_instruction_fetch;
   import riscv_pkg::*;

   localparam logic [ALEN-1:0] RESET_PC = '0;

   logic            clk;
   logic            rst_n;
   logic            redirect_valid;
   logic [ALEN-1:0] redirect_pc;
   logic            imem_en;
   logic [ALEN-1:0] imem_addr;
   logic [31:0]     imem_instr;
   logic            if_valid;
   logic            if_ready;
   logic [ALEN-1:0] if_pc;
   logic [31:0]     if_instr;

   int n_checks = 0;
   int n_fail   = 0;
   int accepted = 0;

   instruction_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [ALEN-1:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
   endfunction

   // ROM with one cycle of read latency; garbage when not enabled.
   always @(posedge clk) begin
      if (imem_en) imem_instr <= rom_word(imem_addr);
      else         imem_instr <= $urandom;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rdy, input logic rv, input logic [ALEN-1:0] rpc);
      @(negedge clk);
      #1;
      rst_n          = r;
      if_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   // Reference model: the presented stream is consecutive PCs from the last reset or
   // redirect target; the fetch address stream is the same sequence, one per issue.
   logic [ALEN-1:0] exp_q [$];
   logic [ALEN-1:0] exp_fetch;
   logic [ALEN-1:0] tgt;
   logic [ALEN-1:0] exp_pc;
   int              since      = 1000;
   int              low_cnt    = 0;
   bit              from_reset = 1'b0;

   always begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
         check("en_in_reset", 32'(imem_en), 32'd0);
         exp_q.delete();
         exp_q.push_back(RESET_PC);
         exp_fetch  = RESET_PC;
         since      = -1;
         from_reset = 1'b1;
         low_cnt    = 0;
      end else begin
         if (since < 1000) since++;
         low_cnt = if_ready ? 0 : low_cnt + 1;
         tgt     = {redirect_pc[ALEN-1:2], 2'b00};

         if (from_reset && since == 0) begin
            check("rst_if_valid", 32'(if_valid), 32'd0);
            check("rst_if_pc", if_pc, 32'd0);
            check("rst_if_instr", if_instr, NOP_INSTR);
            check("first_issue_en", 32'(imem_en), 32'd1);
         end
         if (since == 1) check("flush_slot_empty", 32'(if_valid), 32'd0);
         if (since == 2) check("latency_2", 32'(if_valid), 32'd1);

         if (redirect_valid) begin
            check("redirect_en", 32'(imem_en), 32'd1);
            check("redirect_addr", imem_addr, tgt);
            exp_fetch = tgt + 32'd4;
         end else if (imem_en) begin
            check("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
         end

         if (!redirect_valid && low_cnt >= 3 && since >= 3) begin
            check("stall_no_issue", 32'(imem_en), 32'd0);
            check("stall_fifo_full", 32'(if_valid), 32'd1);
         end

         if (if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_accept", if_pc, 32'hFFFF_FFFF);
            end else begin
               exp_pc = exp_q.pop_front();
               check("if_pc", if_pc, exp_pc);
               check("if_instr", if_instr, rom_word(exp_pc));
               accepted++;
            end
         end

         if (redirect_valid) begin
            exp_q.delete();
            exp_q.push_back(tgt);
            since      = 0;
            from_reset = 1'b0;
         end
      end
      while (exp_q.size() > 0 && exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
   end

   initial begin
      rst_n          = 1'b0;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_instr     = '0;

      repeat (2) drive(1'b0, 1'b1, 1'b0, '0);
      repeat (12) drive(1'b1, 1'b1, 1'b0, '0);
      repeat (10) drive(1'b1, 1'b0, 1'b0, '0);
      repeat (8) drive(1'b1, 1'b1, 1'b0, '0);

      drive(1'b1, 1'b1, 1'b1, 32'h0000_001C);
      repeat (8) drive(1'b1, 1'b1, 1'b0, '0);

      drive(1'b1, 1'b1, 1'b1, 32'h0000_0023);
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
      repeat (8) drive(1'b1, 1'b1, 1'b0, '0);

      drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFA);
      repeat (8) drive(1'b1, 1'b1, 1'b0, '0);

      repeat (5) drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b0, '0);
      repeat (10) drive(1'b1, 1'b1, 1'b0, '0);

      for (int i = 0; i < 800; i++) begin
         logic [ALEN-1:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom);
         drive($urandom_range(0, 99) != 0,
               $urandom_range(0, 9) < 7,
               $urandom_range(0, 14) == 0,
               rpc);
      end
      repeat (6) drive(1'b1, 1'b1, 1'b0, '0);

      @(negedge clk);
      #5;
      check("throughput", 32'(accepted > 300), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
